// File: rtl/mem_bus_unit.sv
// Word-addressed data memory / bus slave with programmable wait states and a stall output.
// Optional MEM_ACCESS_COUNT_EN adds 16-bit read/write access counters.
module mem_bus_unit #(
  parameter int datalines   = 32,
  parameter int adlines     = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [adlines-1:0]   addressbus,
  input  logic                 read,
  input  logic                 write,
  inout  wire  [datalines-1:0] databus,
  output logic                 enable,
  output logic                 busy,
  output logic                 bus_err
`ifdef MEM_ACCESS_COUNT_EN
  ,
  output logic [15:0]          rd_count,
  output logic [15:0]          wr_count
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [1:0] S_START = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;

  logic [datalines-1:0] mem [2**adlines];

  logic [1:0]           state_q, state_d;
  logic [adlines-1:0]   addr_q, addr_d;
  logic                 op_q, op_d;          // 1 = write
  logic [datalines-1:0] wdata_q, wdata_d;
  logic [datalines-1:0] rdata_q, rdata_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 err_q, err_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_HOLD: begin
        // A write seen in HOLD starts a new access; a held read in HOLD just keeps the data up.
        if (read && write) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (write || (read && state_q == S_IDLE)) begin
          addr_d  = addressbus;
          op_d    = write;
          if (write) wdata_d = databus;
          cnt_d   = WS_LOAD;
          state_d = S_START;
        end else if (state_q == S_HOLD && !read) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ACCESS: begin
        if (op_q) begin
          state_d = S_IDLE;
        end else begin
          rdata_d = mem[addr_q];
          state_d = S_HOLD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      op_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Array is not reset; a reset during ACCESS suppresses the commit.
  always_ff @(posedge clk) begin
    if (!reset && state_q == S_ACCESS && op_q) mem[addr_q] <= wdata_q;
  end

`ifdef MEM_ACCESS_COUNT_EN
  logic [15:0] rdc_q, wrc_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      rdc_q <= 16'd0;
      wrc_q <= 16'd0;
    end else if (state_q == S_ACCESS) begin
      if (op_q) wrc_q <= wrc_q + 16'd1;
      else      rdc_q <= rdc_q + 16'd1;
    end
  end
  assign rd_count = rdc_q;
  assign wr_count = wrc_q;
`endif

  assign enable  = (state_q == S_IDLE) || (state_q == S_HOLD);
  assign busy    = (state_q == S_WAIT) || (state_q == S_ACCESS);
  assign bus_err = err_q;
  assign databus = (state_q == S_HOLD && read) ? rdata_q : 'z;

endmodule
